// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULTU/DIVU sequencer owning HI/LO, with single-cycle MTHI/MTLO
//   clk, rst_n (async, active low); start/op/sgn/src_a/src_b issue an op; cancel flushes
//   busy while not idle, done/dbz pulse on commit, hi/lo are the architectural registers
//   MULDIV_SIGNED_EN enables signed MULT/DIV when sgn=1
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t state, state_nx;
  logic [2*WIDTH-1:0] acc, acc_mul, acc_div, acc_neg;
  logic [WIDTH-1:0] opnd, mag_a, mag_b, res_hi, res_lo;
  logic [WIDTH:0] msum, trial;
  logic [CNT_W-1:0] cnt;
  logic dbz_arm, neg_p, neg_r, is_div, sgn_a, sgn_b, b_zero, last;
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    sgn_a = sgn & src_a[WIDTH-1];
    sgn_b = sgn & src_b[WIDTH-1];
`else
    sgn_a = sgn & 1'b0;
    sgn_b = 1'b0;
`endif
    mag_a = sgn_a ? -src_a : src_a;
    mag_b = sgn_b ? -src_b : src_b;
  end
  assign b_zero = src_b == '0;
  assign last = cnt == CNT_W'(WIDTH - 1);
  // acc is {hi_w, lo_w}: product accumulator in MUL, {rem, quo} in DIV
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? opnd : '0};
  assign acc_mul = {msum, acc[WIDTH-1:1]};
  assign trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
  assign acc_div = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign acc_neg = -acc;
  assign res_hi = is_div ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                         : (neg_p ? acc_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]);
  assign res_lo = is_div ? (neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0])
                         : (neg_p ? acc_neg[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign busy = state != IDLE;
  assign done = state == FIN && !cancel;
  assign dbz = done && dbz_arm;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = op == 2'b00 ? MUL : op == 2'b01 ? (b_zero ? FIN : DIV) : IDLE;
      MUL, DIV: if (last) state_nx = FIN;
      default: state_nx = IDLE;
    endcase
    if (cancel) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
      acc <= '0;
      opnd <= '0;
      cnt <= '0;
      dbz_arm <= 1'b0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      is_div <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !cancel) begin
          if (op == 2'b10) hi <= src_a;
          if (op == 2'b11) lo <= src_a;
          cnt <= '0;
          opnd <= op[0] ? mag_b : mag_a;
          acc <= !op[0] ? {{WIDTH{1'b0}}, mag_b} : b_zero ? {src_a, {WIDTH{1'b1}}}
                                                          : {{WIDTH{1'b0}}, mag_a};
          dbz_arm <= op[0] && b_zero;
          is_div <= op[0];
          // divide by zero commits the raw fill pattern, so no sign fix-up
          neg_p <= (sgn_a ^ sgn_b) && !(op[0] && b_zero);
          neg_r <= sgn_a && !b_zero;
        end
        MUL: begin
          acc <= acc_mul;
          cnt <= cnt + CNT_W'(1);
        end
        DIV: begin
          acc <= acc_div;
          cnt <= cnt + CNT_W'(1);
        end
        default: if (!cancel) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      endcase
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq against an arithmetic model
module tb_muldiv_seq;
  localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  logic clk, rst_n, start, sgn, cancel, busy, done, dbz;
  logic [1:0] op;
  logic [W-1:0] src_a, src_b, hi, lo, exp_hi, exp_lo;
  int checks, failures;
  muldiv_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sgn(sgn), .src_a(src_a),
    .src_b(src_b), .cancel(cancel), .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [64:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic s);
    longint sa, sb;
    logic [63:0] p;
    logic [W-1:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'b00) begin
      p = {32'b0, a} * {32'b0, b};
      if (s && SIGNED_EN) p = sa * sb;
      return {1'b0, p};
    end
    if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
    q = a / b;
    r = a % b;
    if (s && SIGNED_EN) begin
      p = sa / sb;
      q = p[31:0];
      p = sa % sb;
      r = p[31:0];
    end
    return {1'b0, r, q};
  endfunction
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s);
    logic [64:0] e;
    int k, nb, lat;
    e = model(o, a, b, s);
    lat = (o == 2'b01 && b == 0) ? 1 : W + 1;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; sgn = s;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    nb = 0;
    while (!done && k < 80) begin
      nb += int'(busy);
      @(negedge clk);
      k++;
    end
    nb += int'(busy);
    chk("latency", 64'(k), 64'(lat));
    chk("busy_cycles", 64'(nb), 64'(lat));
    chk("dbz", 64'(dbz), 64'(e[64]));
    @(negedge clk);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    chk("op_hi", 64'(hi), 64'(exp_hi));
    chk("op_lo", 64'(lo), 64'(exp_lo));
    chk("op_idle", {62'b0, busy, done}, 64'd0);
  endtask
  task automatic mt(input logic [1:0] o, input logic [W-1:0] a);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = $urandom; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (o == 2'b10) exp_hi = a;
    else exp_lo = a;
    chk("mt_idle", {62'b0, busy, done}, 64'd0);
    chk("mt_hi", 64'(hi), 64'(exp_hi));
    chk("mt_lo", 64'(lo), 64'(exp_lo));
  endtask
  initial begin
    logic seen;
    logic [1:0] o;
    logic [W-1:0] a, b;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; sgn = 1'b0; cancel = 1'b0;
    src_a = '0; src_b = '0; exp_hi = '0; exp_lo = '0;
    #12;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_flags", {61'b0, busy, done, dbz}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // reset mid-multiply
    mt(2'b10, 32'h55);
    mt(2'b11, 32'h66);
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 7; src_b = 6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_hi", 64'(hi), 64'd0);
    chk("rstmid_lo", 64'(lo), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= done; end
    chk("rstmid_nodone", 64'(seen), 64'd0);
    // directed arithmetic
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("mul_max_hi", 64'(hi), 64'hFFFF_FFFE);
    do_op(2'b01, 100, 7, 1'b0);
    chk("div_100_7", {hi, lo}, {32'd2, 32'd14});
    do_op(2'b01, 5, 0, 1'b0);
    chk("div_by_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    // back-to-back MTHI/MTLO
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'h1234;
    @(negedge clk);
    seen = busy;
    op = 2'b11; src_a = 32'hABCD;
    @(negedge clk);
    seen |= busy;
    start = 1'b0;
    exp_hi = 32'h1234; exp_lo = 32'hABCD;
    chk("mt_pair", {hi, lo}, {exp_hi, exp_lo});
    chk("mt_pair_busy", 64'(seen), 64'd0);
    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 3; src_b = 5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    chk("ign_hi", 64'(hi), 64'(exp_hi));
    chk("ign_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    chk("ign_done", 64'(done), 64'd1);
    @(negedge clk);
    exp_hi = 0; exp_lo = 15;
    chk("ign_result", {hi, lo}, {exp_hi, exp_lo});
    // cancel mid-divide
    mt(2'b10, 32'hA);
    mt(2'b11, 32'hB);
    @(negedge clk);
    start = 1'b1; op = 2'b01; src_a = 9; src_b = 3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cxl_busy", 64'(busy), 64'd0);
    chk("cxl_hilo", {hi, lo}, {32'hA, 32'hB});
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= done; end
    chk("cxl_nodone", 64'(seen), 64'd0);
    // cancel during the commit cycle
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 9; src_b = 9;
    @(negedge clk);
    start = 1'b0;
    repeat (W) @(negedge clk);
    chk("fin_done", 64'(done), 64'd1);
    cancel = 1'b1;
    #1;
    chk("fin_cxl_done", {62'b0, done, dbz}, 64'd0);
    @(negedge clk);
    cancel = 1'b0;
    chk("fin_cxl_busy", 64'(busy), 64'd0);
    chk("fin_cxl_hilo", {hi, lo}, {32'hA, 32'hB});
    // cancel in idle drops MTHI
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'b10; src_a = 32'h777;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("idle_cxl_hi", 64'(hi), 64'hA);
    // signed-request stimulus; unsigned results in the default build
    do_op(2'b01, 32'hFFFF_FFF9, 2, 1'b1);
    do_op(2'b00, 32'hFFFF_FFFD, 4, 1'b1);
    // random mix
    repeat (40) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 0 : ($urandom_range(0, 1) != 0) ? $urandom
                                                                          : $urandom_range(1, 20);
      if (o[1]) mt(o, a);
      else do_op(o, a, b, 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer for the MIPS pipeline EX stage.
- Owns the HI/LO architectural registers.
- Iterates a shift/add-subtract datapath over WIDTH cycles for MULTU/DIVU, and handles MTHI/MTLO in a single cycle.
- Exposes busy/done so the hazard logic can stall MFHI/MFLO and later mul/div ops until the result commits.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  issue request, sampled each cycle.
- op  input  2  operation: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
- sgn  input  1  signed-op request; honoured only with MULDIV_SIGNED_EN.
- src_a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- src_b  input  WIDTH  multiplier / divisor.
- cancel  input  1  pipeline flush; aborts an in-flight op.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse on result commit.
- dbz  output  1  one-cycle pulse, coincident with done, on divide by zero.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any state): hi=0, lo=0, busy=0, done=0, dbz=0, state=IDLE, counter=0, working registers=0.
- States: IDLE, MUL, DIV, FIN.
- IDLE, start=1, cancel=0:
  - op=10: hi<=src_a next edge; stay IDLE; no busy, no done.
  - op=11: lo<=src_a next edge; stay IDLE; no busy, no done.
  - op=00: latch operands into working regs; acc={WIDTH'0, src_b}, mcand=src_a, counter=0; go to MUL.
  - op=01, src_b!=0: rem=0, quo=src_a, dvsr=src_b, counter=0; go to DIV.
  - op=01, src_b==0: go to FIN with result hi_w=src_a, lo_w=all ones, dbz armed.
- MUL (one step per cycle):
  - If acc[0]: acc[2W-1:W] += mcand, with carry into a W+1-bit sum.
  - Then shift {carry,acc} right by 1.
  - After WIDTH steps (counter==WIDTH-1): go to FIN; hi_w=acc upper half, lo_w=acc lower half.
- DIV (restoring, one step per cycle):
  - {rem,quo} shifted left 1; trial = rem - dvsr at W+1 bits.
  - If trial is non-negative: rem=trial, quo[0]=1; otherwise quo[0]=0.
  - After WIDTH steps: go to FIN; hi_w=rem, lo_w=quo.
- FIN (one cycle): hi<=hi_w, lo<=lo_w, done=1, dbz=1 if armed; next state IDLE.
- HI/LO change only in FIN or on MTHI/MTLO. An aborted op leaves the prior HI/LO intact.
- Latency:
  - start at edge N → done high during cycle N+WIDTH+1 (MUL/DIV), or cycle N+1 (div by zero).
  - New hi/lo are visible from the cycle after done.
- busy=1 in MUL, DIV, FIN. start while busy is ignored: no queuing, no error.
- cancel=1 in MUL/DIV/FIN (FIN: before commit edge): return to IDLE next edge; no commit, no done, no dbz. Cancel has priority over start and over commit.
- cancel=1 in IDLE: the same-cycle start is dropped, including MTHI/MTLO.
- Unsigned arithmetic is exact mod 2^(2W) for multiply. No overflow flag.

Optional Feature:
- MULDIV_SIGNED_EN defined:
  - When sgn=1 with op 00/01: operands are converted to magnitudes at latch.
  - Signs are recorded in working regs.
  - At FIN, before commit: product negated if sign_a^sign_b; quotient negated if sign_a^sign_b; remainder takes the sign of the dividend.
  - Divide by zero result is unchanged: hi=src_a, lo=all ones.
  - Latency is unchanged.
- Not defined: sgn is ignored; all ops are unsigned. Port list is identical in both builds.

Test Plan:
- Reset mid-MUL: start MULTU 7×6, assert rst_n=0 at iteration 10 → hi=lo=0, busy=0 immediately; no done after release.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → done at start+33; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- DIVU 100/7 → hi=2, lo=14, dbz=0. DIVU 5/0 → done and dbz pulse the next cycle; hi=5, lo=0xFFFFFFFF.
- MTHI 0x1234 then MTLO 0xABCD on consecutive cycles → hi=0x1234, lo=0xABCD; busy never asserted. A start issued in MUL state is ignored and hi/lo stay as before.
- Preload HI=0xA, LO=0xB; start DIVU 9/3; cancel at iteration 20 → IDLE next cycle; hi=0xA, lo=0xB; no done. Cancel asserted in the FIN cycle → no commit.
- With MULDIV_SIGNED_EN: sgn=1, DIV -7/2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); MULT -3×4 → hi=0xFFFFFFFF, lo=0xFFFFFFF4. Without the macro, same stimulus gives the unsigned results.
